// File: rtl/tim_copy_pkg.sv
// Shared definitions for the tim_copy block-copy/fill initiator:
// FSM states, the architectural register bundle and its reset value.
package tim_copy_wires;

    localparam int unsigned MAX_CNT_W = 32;
    localparam logic [31:0] WORD_STEP = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FIN
    } state_t;

    // remaining is sized for the widest supported word_count; narrower counts are zero-extended.
    typedef struct packed {
        state_t                 state;
        logic [31:0]            src;
        logic [31:0]            dst;
        logic [MAX_CNT_W-1:0]   remaining;
        logic [31:0]            data;
        logic [31:0]            fill;
        logic                   mode;
        logic                   error;
    } regs_t;

    localparam regs_t REGS_INIT = '{
        state:     IDLE,
        src:       32'h0,
        dst:       32'h0,
        remaining: '0,
        data:      32'h0,
        fill:      32'h0,
        mode:      1'b0,
        error:     1'b0
    };

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/tim_copy.sv
// Block copy / fill engine that masters the TIM valid/addr/wdata/wstrb port set,
// keeping exactly one request outstanding and pulsing done on completion or abort.
module tim_copy
    import tim_copy_wires::*;
#(
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [cnt_width-1:0] word_count,
    input  logic [31:0]          fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 mem_valid,
    output logic                 mem_instr,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    input  logic                 mem_error
);

    regs_t       regs_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        done_q;

    // Requests are launched on the edge that enters RD_REQ/WR_REQ, so mem_valid
    // is high for exactly the one cycle spent in the *_REQ state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            regs_q      <= REGS_INIT;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            done_q      <= 1'b0;
        end else begin
            mem_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (regs_q.state)
                IDLE: begin
                    if (start) begin
                        regs_q.src       <= word_align(src_addr);
                        regs_q.dst       <= word_align(dst_addr);
                        regs_q.remaining <= MAX_CNT_W'(word_count);
                        regs_q.fill      <= fill_data;
                        regs_q.mode      <= mode;
                        regs_q.error     <= 1'b0;
                        if (word_count == '0) begin
                            regs_q.state <= FIN;
                        end else if (mode) begin
                            regs_q.state <= WR_REQ;
                            mem_valid_q  <= 1'b1;
                            mem_addr_q   <= word_align(dst_addr);
                            mem_wdata_q  <= fill_data;
                            mem_wstrb_q  <= 4'hF;
                        end else begin
                            regs_q.state <= RD_REQ;
                            mem_valid_q  <= 1'b1;
                            mem_addr_q   <= word_align(src_addr);
                            mem_wdata_q  <= 32'h0;
                            mem_wstrb_q  <= 4'h0;
                        end
                    end
                end
                RD_REQ: regs_q.state <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_ready) begin
                        if (mem_error) begin
                            regs_q.error <= 1'b1;
                            regs_q.state <= FIN;
                            done_q       <= 1'b1;
                        end else begin
                            regs_q.data  <= mem_rdata;
                            regs_q.src   <= regs_q.src + WORD_STEP;
                            regs_q.state <= WR_REQ;
                            mem_valid_q  <= 1'b1;
                            mem_addr_q   <= regs_q.dst;
                            mem_wdata_q  <= mem_rdata;
                            mem_wstrb_q  <= 4'hF;
                        end
                    end
                end
                WR_REQ: regs_q.state <= WR_WAIT;
                WR_WAIT: begin
                    if (mem_ready) begin
                        if (mem_error) begin
                            regs_q.error <= 1'b1;
                            regs_q.state <= FIN;
                            done_q       <= 1'b1;
                        end else begin
                            regs_q.dst       <= regs_q.dst + WORD_STEP;
                            regs_q.remaining <= regs_q.remaining - MAX_CNT_W'(1);
                            if (regs_q.remaining == MAX_CNT_W'(1)) begin
                                regs_q.state <= FIN;
                                done_q       <= 1'b1;
                            end else if (regs_q.mode) begin
                                regs_q.state <= WR_REQ;
                                mem_valid_q  <= 1'b1;
                                mem_addr_q   <= regs_q.dst + WORD_STEP;
                                mem_wdata_q  <= regs_q.fill;
                                mem_wstrb_q  <= 4'hF;
                            end else begin
                                regs_q.state <= RD_REQ;
                                mem_valid_q  <= 1'b1;
                                mem_addr_q   <= regs_q.src;
                                mem_wdata_q  <= 32'h0;
                                mem_wstrb_q  <= 4'h0;
                            end
                        end
                    end
                end
                // A zero-count start lands here with done low, so it spends one extra cycle.
                FIN: begin
                    if (done_q) begin
                        regs_q.state <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: regs_q <= REGS_INIT;
            endcase
        end
    end

    assign busy      = (regs_q.state != IDLE);
    assign done      = done_q;
    assign error     = regs_q.error;
    assign mem_valid = mem_valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_tim_copy.sv
// Self-checking bench for tim_copy: a variable-latency TIM responder with error
// injection, plus a word-level reference model of the expected request stream.
module tb_tim_copy;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] srcAddr = 32'h0;
    logic [31:0] dstAddr = 32'h0;
    logic [15:0] wordCount = 16'h0;
    logic [31:0] fillData = 32'h0;
    logic        busy;
    logic        done;
    logic        errorOut;
    logic        memValid;
    logic        memInstr;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic [31:0] memRdata = 32'h0;
    logic        memReady = 1'b0;
    logic        memError = 1'b0;

    int checks = 0;
    int failures = 0;

    int respLat = 1;
    int errAtRead = -1;
    int readCount = 0;
    int protoErr = 0;
    int logBase = 0;
    logic [31:0] seed = 32'h0;

    txn_t reqLog[$];
    txn_t expQ[$];
    logic [31:0] tim[logic [31:0]];
    logic [31:0] refMem[logic [31:0]];

    tim_copy #(.cnt_width(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (srcAddr),
        .dst_addr   (dstAddr),
        .word_count (wordCount),
        .fill_data  (fillData),
        .busy       (busy),
        .done       (done),
        .error      (errorOut),
        .mem_valid  (memValid),
        .mem_instr  (memInstr),
        .mem_addr   (memAddr),
        .mem_wdata  (memWdata),
        .mem_wstrb  (memWstrb),
        .mem_rdata  (memRdata),
        .mem_ready  (memReady),
        .mem_error  (memError)
    );

    always #5 clock = ~clock;

    // Untouched memory reads back a pattern: 1,2,3,4 at 0x0-0xC, a seeded hash elsewhere.
    function automatic logic [31:0] initWord(input logic [31:0] a);
        if (a < 32'h10) return (a >> 2) + 32'd1;
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] timRead(input logic [31:0] a);
        if (tim.exists(a)) return tim[a];
        return initWord(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initWord(a);
    endfunction

    // Responder: answers each request respLat cycles after its valid cycle and
    // flags any second request issued while one is still outstanding.
    logic        prevValid = 1'b0;
    int          pendCnt = 0;
    logic        pendWr = 1'b0;
    logic        pendErr = 1'b0;
    logic [31:0] pendAddr = 32'h0;
    logic [31:0] pendData = 32'h0;

    always @(posedge clock) begin
        memReady <= 1'b0;
        memError <= 1'b0;
        memRdata <= 32'h0;
        if (!reset) begin
            pendCnt = 0;
            prevValid = 1'b0;
        end else begin
            if (memValid) begin
                if (prevValid || pendCnt != 0) protoErr++;
                reqLog.push_back('{memWstrb != 4'h0, memWstrb, memAddr, memWdata});
                pendWr = (memWstrb != 4'h0);
                pendAddr = memAddr;
                pendData = memWdata;
                pendErr = 1'b0;
                if (!pendWr) begin
                    readCount++;
                    pendErr = (readCount == errAtRead);
                end
                pendCnt = respLat;
            end
            prevValid = memValid;
            if (pendCnt > 0) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    memReady <= 1'b1;
                    memError <= pendErr;
                    if (pendWr) begin
                        if (!pendErr) tim[pendAddr] = pendData;
                    end else begin
                        memRdata <= timRead(pendAddr);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelFill(input logic [31:0] d, input int n, input logic [31:0] f);
        logic [31:0] da;
        da = d & ~32'h3;
        for (int i = 0; i < n; i++) begin
            expQ.push_back('{1'b1, 4'hF, da, f});
            refMem[da] = f;
            da += 32'd4;
        end
    endtask

    task automatic modelCopy(input logic [31:0] s, input logic [31:0] d, input int n, input int abortRead);
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] v;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        for (int i = 0; i < n; i++) begin
            v = refRead(sa);
            expQ.push_back('{1'b0, 4'h0, sa, 32'h0});
            if (i + 1 == abortRead) return;
            expQ.push_back('{1'b1, 4'hF, da, v});
            refMem[da] = v;
            sa += 32'd4;
            da += 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] n, input logic [31:0] f, input int pokeAt,
                                 input string tag, output int doneCyc);
        @(negedge clock);
        logBase = reqLog.size();
        mode = m;
        srcAddr = s;
        dstAddr = d;
        wordCount = n;
        fillData = f;
        start = 1'b1;
        @(posedge clock);
        doneCyc = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (k == pokeAt) begin
                start = 1'b1;
                mode = ~m;
                srcAddr = 32'h700;
                dstAddr = 32'h600;
                wordCount = 16'd1;
                fillData = 32'h0BAD_0BAD;
            end else begin
                start = 1'b0;
            end
            if (k == 1) checkOutput({tag, " busy@1"}, busy, 1'b1);
            if (done === 1'b1) begin
                doneCyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic runCase(input string tag, input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic [31:0] f, input int pokeAt,
                           input int expDone, input logic expErr);
        int doneCyc;
        applyStimulus(m, s, d, n, f, pokeAt, tag, doneCyc);
        checkOutput({tag, " done cycle"}, doneCyc, expDone);
        checkOutput({tag, " error"}, errorOut, expErr);
        @(negedge clock);
        checkOutput({tag, " done pulse"}, {busy, done}, 2'b00);
        checkOutput({tag, " request count"}, reqLog.size() - logBase, expQ.size());
        for (int i = 0; i < expQ.size() && logBase + i < reqLog.size(); i++)
            checkOutput($sformatf("%s txn%0d", tag, i), reqLog[logBase + i], expQ[i]);
        checkOutput({tag, " protocol"}, protoErr, 0);
    endtask

    initial begin
        int lat;
        int n;
        logic m;
        logic [31:0] s;
        logic [31:0] d;
        logic [31:0] f;
        seed = $urandom;
        $display("[TB] tim_copy bench starting");

        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset mem_valid", memValid, 1'b0);
        checkOutput("reset mem_addr", memAddr, 32'h0);
        checkOutput("reset mem_wdata", memWdata, 32'h0);
        checkOutput("reset mem_wstrb", memWstrb, 4'h0);
        checkOutput("reset mem_instr", memInstr, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset error", errorOut, 1'b0);
        reset = 1'b1;

        respLat = 1;
        expQ.delete();
        modelFill(32'h100, 4, 32'hDEAD_BEEF);
        runCase("fill4", 1'b1, 32'h0, 32'h100, 16'd4, 32'hDEAD_BEEF, 0, 9, 1'b0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("fill4 readback%0d", i), timRead(32'h100 + 32'(i * 4)), 32'hDEAD_BEEF);

        expQ.delete();
        modelCopy(32'h0, 32'h40, 4, 0);
        runCase("copy4", 1'b0, 32'h0, 32'h40, 16'd4, 32'h0, 0, 17, 1'b0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("copy4 readback%0d", i), timRead(32'h40 + 32'(i * 4)), 32'(i + 1));

        expQ.delete();
        runCase("zero", 1'b0, 32'h0, 32'h80, 16'd0, 32'h0, 0, 2, 1'b0);

        respLat = 3;
        expQ.delete();
        modelCopy(32'h200, 32'h300, 2, 0);
        runCase("stall copy2", 1'b0, 32'h200, 32'h300, 16'd2, 32'h0, 0, 2 * 2 * 4 + 1, 1'b0);

        respLat = 1;
        errAtRead = readCount + 2;
        expQ.delete();
        modelCopy(32'h20, 32'h400, 4, 2);
        runCase("err read2", 1'b0, 32'h20, 32'h400, 16'd4, 32'h0, 0, 7, 1'b1);
        errAtRead = -1;
        repeat (4) @(negedge clock);
        checkOutput("err no further requests", reqLog.size() - logBase, 3);
        checkOutput("err sticky", errorOut, 1'b1);
        expQ.delete();
        runCase("err cleared", 1'b0, 32'h0, 32'h0, 16'd0, 32'h0, 0, 2, 1'b0);

        lat = $urandom_range(1, 3);
        respLat = lat;
        expQ.delete();
        modelFill(32'hFFFF_FFF8, 3, 32'h1234_5678);
        runCase("wrap fill", 1'b1, 32'h0, 32'hFFFF_FFF8, 16'd3, 32'h1234_5678, 0, 3 * (lat + 1) + 1, 1'b0);
        checkOutput("wrap third addr", reqLog[logBase + 2].addr, 32'h0);

        respLat = 1;
        expQ.delete();
        modelCopy(32'h500, 32'h540, 3, 0);
        runCase("start ignored", 1'b0, 32'h500, 32'h540, 16'd3, 32'h0, 3, 13, 1'b0);

        for (int it = 0; it < 4; it++) begin
            lat = $urandom_range(1, 3);
            n = $urandom_range(1, 6);
            m = 1'($urandom_range(0, 1));
            s = 32'($urandom_range(0, 32'h3FF));
            d = 32'($urandom_range(0, 32'h3FF));
            f = $urandom;
            respLat = lat;
            expQ.delete();
            if (m) modelFill(d, n, f);
            else modelCopy(s, d, n, 0);
            runCase($sformatf("rand%0d", it), m, s, d, 16'(n), f, 0,
                    m ? n * (lat + 1) + 1 : 2 * n * (lat + 1) + 1, 1'b0);
        end

        respLat = 2;
        @(negedge clock);
        mode = 1'b0;
        srcAddr = 32'h0;
        dstAddr = 32'h800;
        wordCount = 16'd4;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("midreset mem_valid", memValid, 1'b0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset done", done, 1'b0);
        reset = 1'b1;

        expQ.delete();
        modelFill(32'h900, 2, 32'hCAFE_F00D);
        runCase("post reset fill", 1'b1, 32'h0, 32'h900, 16'd2, 32'hCAFE_F00D, 0, 2 * 3 + 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tim_copy.md
# tim_copy

Memory-protocol initiator that copies a block of 32-bit words from one address range to another, or fills a range with a constant. It drives the same valid/addr/wdata/wstrb → rdata/ready port set that the tightly-integrated memory answers, and sits between a control source (core CSR or test logic) and that memory. It is the bus-master counterpart to the TIM responder and serves preload, clear, and relocation of TIM contents.

## Interface
Parameters:
- cnt_width, 16, width of word_count and of the internal remaining-word counter

Ports:
- reset  in  1  synchronous, active-low
- clock  in  1  rising-edge clock
- start  in  1  one-cycle request; honoured only in IDLE
- mode  in  1  0 = copy (read src, write dst), 1 = fill (write fill_data to dst)
- src_addr  in  32  source byte address, sampled on accepted start; bits [1:0] ignored
- dst_addr  in  32  destination byte address, sampled on accepted start; bits [1:0] ignored
- word_count  in  cnt_width  number of words, sampled on accepted start
- fill_data  in  32  fill word, sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion or abort
- error  out  1  sticky; set on mem_error, cleared by the next accepted start
- mem_valid  out  1  one-cycle request pulse
- mem_instr  out  1  constant 0
- mem_addr  out  32  request address; bits [1:0] always 0
- mem_wdata  out  32  write data; 0 on reads
- mem_wstrb  out  4  4'hF for writes, 4'h0 for reads
- mem_rdata  in  32  read data, valid with mem_ready
- mem_ready  in  1  response strobe
- mem_error  in  1  response error, qualified by mem_ready

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE + start: latch the inputs and clear error. Go to FIN if word_count == 0, to WR_REQ if mode == 1, otherwise to RD_REQ.
- RD_REQ: mem_valid = 1, mem_addr = src, mem_wstrb = 0. Then go to RD_WAIT.
- RD_WAIT: on mem_ready, capture mem_rdata into the data register, add 4 to src, and go to WR_REQ.
- WR_REQ: mem_valid = 1, mem_addr = dst, mem_wdata = data register (copy) or fill word (fill), mem_wstrb = 4'hF. Then go to WR_WAIT.
- WR_WAIT: on mem_ready, add 4 to dst and decrement remaining. If remaining becomes 0, go to FIN. Otherwise go to RD_REQ (copy) or WR_REQ (fill).
- FIN: done = 1 for one cycle, then go to IDLE.
- Any mem_ready with mem_error = 1 in RD_WAIT or WR_WAIT sets error and goes to FIN. No further requests are issued.
- Address arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- start in any state other than IDLE is ignored; latched parameters do not change.
- Overlapping src/dst ranges are not detected. The copy runs ascending, so dst > src with overlap smears data; this is the documented behaviour.

## Timing
- Reset values: mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, mem_instr 0, busy 0, done 0, error 0, state IDLE.
- Reset asserted mid-transfer: the state returns to IDLE at that edge and mem_valid is 0 from the next cycle. The outstanding response is discarded.
- Request outputs are registered.
- Exactly one request is outstanding at a time. mem_ready is accepted only in a *_WAIT state, never in the cycle mem_valid is high. Response latency is unbounded and at least 1 cycle.
- With a 1-cycle responder and start accepted at edge 0, the first mem_valid is in cycle 1.
- Copy costs 4 cycles/word; the last write's ready is in cycle 4N and done in cycle 4N+1.
- Fill costs 2 cycles/word; done in cycle 2N+1.
- word_count = 0: done in cycle 2, with no memory access.
- busy is high in every non-IDLE state, including FIN.

## Structure
- Package tim_copy_wires holds the state enum, the register struct (state, src, dst, remaining, data, fill, mode, error), and its init constant.
- Single module, no sub-module.
- Bench instantiates the existing tim as the responder, plus a variable-latency responder model for stall and error tests.

## Test plan
- Fill: dst 0x100, count 4, data 0xDEADBEEF. Expect 4 writes at 0x100–0x10C, wstrb F, done in cycle 9; TIM reads back 0xDEADBEEF ×4.
- Copy: preload 0x0–0xC with 1,2,3,4; src 0x0, dst 0x40, count 4. Expect alternating rd/wr, done in cycle 17; 0x40–0x4C read back 1,2,3,4.
- Zero count: count 0. Expect no mem_valid, done in cycle 2, error 0.
- Responder stalls ready 3 cycles per access: copy count 2 completes with correct data, and mem_valid stays single-pulse per request.
- mem_error on the 2nd read of count 4: no further requests, done pulse, error = 1; the next start clears error.
- Wrap and reset: fill dst 0xFFFFFFF8, count 3 writes 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Reset asserted mid-copy forces mem_valid, busy, and done to 0; a start is ignored while busy.
